// File: rtl/addr_seq_ctrl.sv
// addr_seq_ctrl: tile-level sequencer in front of the skewed SRAM read-address selector.
// Issues serial steps 0..tile_len-1 on addr_serial_num (IDLE_NUM when not issuing). It also
// delays data-valid/first/last markers by 1+SRAM_LAT cycles so they line up with SRAM read
// data at the array input.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, tile_len     one-cycle run request (taken only when idle) and step count
//   stall               array backpressure, holds issue while running
//   busy, done          handshake to the tile controller
//   addr_serial_num     serial step to the address selector
//   issue_valid         addr_serial_num carries a new step this cycle
//   data_valid/first/last  markers aligned with SRAM read data
module addr_seq_ctrl #(
  parameter int unsigned SERIAL_W = 7,
  parameter int unsigned IDLE_NUM = 127,
  parameter int unsigned SRAM_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [SERIAL_W-1:0] tile_len,
  input  logic                stall,
  output logic                busy,
  output logic                done,
  output logic [SERIAL_W-1:0] addr_serial_num,
  output logic                issue_valid,
  output logic                data_valid,
  output logic                data_first,
  output logic                data_last
);

  // Issue-to-data delay: selector output register plus SRAM read latency.
  localparam int unsigned Stages = 1 + SRAM_LAT;

  localparam logic [SERIAL_W-1:0] IdleNum   = SERIAL_W'(IDLE_NUM);
  localparam logic [SERIAL_W-1:0] OneStep   = SERIAL_W'(1);
  localparam logic [2:0]          DrainInit = 3'(SRAM_LAT);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e              state_q;
  logic [SERIAL_W-1:0] len_q;
  logic [SERIAL_W-1:0] addr_q;
  logic                issue_valid_q;
  logic                busy_q;
  logic                done_q;
  logic [2:0]          drain_q;

  logic [Stages-1:0]   pipe_v_q;
  logic [Stages-1:0]   pipe_f_q;
  logic [Stages-1:0]   pipe_l_q;

  logic                first_in;
  logic                last_in;

  // While running, addr_q is the step counter itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      len_q         <= '0;
      addr_q        <= IdleNum;
      issue_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      drain_q       <= '0;
    end else begin
      issue_valid_q <= 1'b0;
      done_q        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            len_q  <= tile_len;
            if (tile_len != '0) begin
              // Step 0 goes out regardless of stall.
              addr_q        <= '0;
              issue_valid_q <= 1'b1;
              state_q       <= StRun;
            end else begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end
          end
        end
        StRun: begin
          // On stall the address is held; the repeated read is not marked valid.
          if (!stall) begin
            if (addr_q == len_q - OneStep) begin
              addr_q  <= IdleNum;
              drain_q <= DrainInit;
              state_q <= StDrain;
            end else begin
              addr_q        <= addr_q + OneStep;
              issue_valid_q <= 1'b1;
            end
          end
        end
        StDrain: begin
          // Counts SRAM_LAT..0, i.e. 1+SRAM_LAT cycles, so the last beat leaves before done.
          if (drain_q == '0) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            drain_q <= drain_q - 3'd1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign first_in = issue_valid_q && (addr_q == '0);
  assign last_in  = issue_valid_q && (addr_q == len_q - OneStep);

  // Marker delay line; stage 0 takes the registered issue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v_q <= '0;
      pipe_f_q <= '0;
      pipe_l_q <= '0;
    end else begin
      pipe_v_q <= {pipe_v_q[Stages-2:0], issue_valid_q};
      pipe_f_q <= {pipe_f_q[Stages-2:0], first_in};
      pipe_l_q <= {pipe_l_q[Stages-2:0], last_in};
    end
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign addr_serial_num = addr_q;
  assign issue_valid     = issue_valid_q;
  assign data_valid      = pipe_v_q[Stages-1];
  assign data_first      = pipe_f_q[Stages-1];
  assign data_last       = pipe_l_q[Stages-1];

endmodule

// File: tb/tb_addr_seq_ctrl.sv
// Scoreboard bench for addr_seq_ctrl. On each accepted start a step-level model computes the
// cycle of every issued step, data beat and done from the stall pattern. A negedge monitor
// pops and compares those entries as the DUT presents them.
module tb_addr_seq_ctrl;

  localparam int unsigned LAT    = 1;
  localparam int          MaxCyc = 16384;

  typedef struct {
    int cyc;
    int val;
    bit f;
    bit l;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [6:0] tile_len;
  logic       stall;
  logic       busy, done, issue_valid, data_valid, data_first, data_last;
  logic [6:0] addr_serial_num;

  int  cyc = 0;
  int  tests = 0;
  int  fails = 0;
  bit  mon_en = 1'b0;
  bit  stall_at [MaxCyc];
  bit  exp_busy [MaxCyc];
  ev_t iq[$];
  ev_t dq[$];
  int  oq[$];

  addr_seq_ctrl #(.SERIAL_W(7), .IDLE_NUM(127), .SRAM_LAT(LAT)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .tile_len        (tile_len),
    .stall           (stall),
    .busy            (busy),
    .done            (done),
    .addr_serial_num (addr_serial_num),
    .issue_valid     (issue_valid),
    .data_valid      (data_valid),
    .data_first      (data_first),
    .data_last       (data_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  function automatic bit st(input int i);
    return (i >= 0 && i < MaxCyc) ? stall_at[i] : 1'b0;
  endfunction

  // Inputs change 1 time unit after the edge that starts cycle 'cyc'.
  task automatic step();
    @(posedge clk);
    #1;
    start = 1'b0;
    stall = st(cyc);
  endtask

  // Request a tile in the current cycle T and push the expected response.
  task automatic launch(input int len, output int done_c);
    int t, c, e;
    t = cyc;
    start    = 1'b1;
    tile_len = 7'(len);
    if (len == 0) begin
      done_c = t + 1;
    end else begin
      c = t + 1;
      for (int k = 0; k < len; k++) begin
        if (k > 0) begin
          c++;
          // A step advances only over an edge where stall was low.
          while (st(c - 1)) c++;
        end
        iq.push_back('{cyc: c, val: k, f: 1'b0, l: 1'b0});
        dq.push_back('{cyc: c + 1 + LAT, val: k, f: (k == 0), l: (k == len - 1)});
      end
      e = c;
      while (st(e)) e++;
      // Drain occupies 1+LAT cycles after the final unstalled edge, then done.
      done_c = e + 1 + (1 + LAT);
    end
    for (int i = t + 1; i <= done_c && i < MaxCyc; i++) exp_busy[i] = 1'b1;
    oq.push_back(done_c);
  endtask

  task automatic wait_done(input int done_c, input bit spurious);
    while (cyc < done_c) begin
      step();
      if (spurious && $urandom_range(0, 9) == 0) begin
        start    = 1'b1;
        tile_len = 7'($urandom_range(0, 127));
      end
    end
  endtask

  task automatic quiet(input int from, input int n);
    for (int i = from; i < from + n && i < MaxCyc; i++) stall_at[i] = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t ev;
      while (iq.size() > 0 && iq[0].cyc < cyc) begin
        ev = iq.pop_front();
        check("issue_missing_cycle", cyc, ev.cyc);
      end
      while (dq.size() > 0 && dq[0].cyc < cyc) begin
        ev = dq.pop_front();
        check("data_missing_cycle", cyc, ev.cyc);
      end
      while (oq.size() > 0 && oq[0] < cyc) begin
        check("done_missing_cycle", cyc, oq.pop_front());
      end
      if (issue_valid) begin
        if (iq.size() == 0) check("issue_unexpected", 1, 0);
        else begin
          ev = iq.pop_front();
          check("issue_cycle", cyc, ev.cyc);
          check("issue_addr", int'(addr_serial_num), ev.val);
        end
      end
      if (data_valid) begin
        if (dq.size() == 0) check("data_unexpected", 1, 0);
        else begin
          ev = dq.pop_front();
          check("data_cycle", cyc, ev.cyc);
          check("data_first", int'(data_first), int'(ev.f));
          check("data_last", int'(data_last), int'(ev.l));
        end
      end else begin
        check("first_without_valid", int'(data_first), 0);
        check("last_without_valid", int'(data_last), 0);
      end
      if (done) begin
        if (oq.size() == 0) check("done_unexpected", 1, 0);
        else check("done_cycle", cyc, oq.pop_front());
      end
      if (cyc < MaxCyc) begin
        check("busy", int'(busy), int'(exp_busy[cyc]));
        if (!exp_busy[cyc]) check("idle_addr", int'(addr_serial_num), 127);
      end
    end
  end

  initial begin
    #(MaxCyc * 10);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int d, t, len;
    for (int i = 0; i < MaxCyc; i++) begin
      stall_at[i] = ($urandom_range(0, 4) == 0);
      exp_busy[i] = 1'b0;
    end
    rst_n    = 1'b0;
    start    = 1'b0;
    tile_len = '0;
    stall    = 1'b0;
    repeat (3) step();
    check("reset_addr", int'(addr_serial_num), 127);
    check("reset_issue", int'(issue_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_data_valid", int'(data_valid), 0);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    step();

    // 103 steps, no stall.
    quiet(cyc, 150);
    launch(103, d);
    wait_done(d, 1'b1);
    step();

    // 103 steps with stall sampled at edges T+10..T+12.
    t = cyc;
    quiet(t, 150);
    for (int i = 10; i <= 12; i++) stall_at[t + i] = 1'b1;
    launch(103, d);
    wait_done(d, 1'b1);
    step();

    // Zero-length tile, then a start in the cycle right after done.
    launch(0, d);
    wait_done(d, 1'b0);
    step();
    launch(1, d);
    wait_done(d, 1'b0);
    step();
    launch(127, d);
    wait_done(d, 1'b1);
    step();

    // Reset 40 cycles into a run: abort with no done, then a normal short tile.
    t = cyc;
    launch(103, d);
    while (cyc < t + 40) step();
    rst_n = 1'b0;
    #1;
    check("abort_addr", int'(addr_serial_num), 127);
    check("abort_issue", int'(issue_valid), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_data_valid", int'(data_valid), 0);
    iq.delete();
    dq.delete();
    oq.delete();
    for (int i = cyc; i < MaxCyc; i++) exp_busy[i] = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    quiet(cyc, 20);
    launch(5, d);
    wait_done(d, 1'b0);
    step();

    // Randomised tiles with random stalls, gaps and ignored starts while busy.
    for (int n = 0; n < 30; n++) begin
      case ($urandom_range(0, 9))
        0:       len = 0;
        1:       len = 1;
        2:       len = 127;
        default: len = $urandom_range(2, 126);
      endcase
      launch(len, d);
      wait_done(d, 1'b1);
      repeat ($urandom_range(1, 3)) step();
    end

    repeat (10) step();
    check("issue_queue_empty", iq.size(), 0);
    check("data_queue_empty", dq.size(), 0);
    check("done_queue_empty", oq.size(), 0);
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/addr_seq_ctrl.md
Name: addr_seq_ctrl

Overview:
Tile-level sequencer that sits directly upstream of the skewed SRAM read-address selector in the systolic array. It drives the 7-bit serial step number (addr_serial_num) that the selector turns into skewed weight/data queue addresses. It also generates data-valid, first and last markers, delayed to line up with SRAM read data at the array input. Start/busy/done handshake to the tile controller; stall input from array backpressure.

Parameters:
SERIAL_W, 7, width of addr_serial_num
IDLE_NUM, 127, serial value driven when not issuing (selector maps it to null address 127)
SRAM_LAT, 1, SRAM read latency in cycles (1..4); total issue-to-data delay = 1 + SRAM_LAT (the 1 is the selector's output register)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to run a tile; accepted only when busy=0
tile_len  in  7  number of serial steps (0..127); sampled on accepted start
stall  in  1  hold issue (array backpressure); honoured only in RUN
busy  out  1  high from cycle after accepted start through the done cycle, inclusive
done  out  1  one-cycle pulse after the last data beat
addr_serial_num  out  7  serial step to the address selector
issue_valid  out  1  addr_serial_num is a new, valid step this cycle
data_valid  out  1  issue_valid delayed 1+SRAM_LAT cycles
data_first  out  1  with data_valid, marks step 0
data_last  out  1  with data_valid, marks step tile_len-1

Behaviour:
- All outputs are registered. Async reset (rst_n=0): state=IDLE, addr_serial_num=127, all other outputs 0, delay pipeline cleared, captured length 0. Takes effect immediately, including mid-tile. A tile aborted by reset produces no done.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and tile_len>0: capture len, go to RUN; next cycle addr_serial_num=0, issue_valid=1.
  - start=1 and tile_len=0: go to DONE; no issue.
  - stall is ignored.
- RUN, edge with stall=0:
  - If cnt<len-1: addr_serial_num<=cnt+1, issue_valid<=1.
  - If cnt==len-1: addr_serial_num<=127, issue_valid<=0, go to DRAIN.
- RUN, edge with stall=1: addr_serial_num holds its value, issue_valid<=0. The repeated read is harmless; its data is not marked valid.
- The first step (0) is issued regardless of stall on the start cycle.
- DRAIN: lasts exactly 1+SRAM_LAT cycles (down-counter), then DONE. stall is ignored.
- DONE: done=1 for one cycle, busy=1, then IDLE.
- start while busy=1 is ignored; there is no queuing.
- busy=1 in RUN, DRAIN and DONE.
- Marker pipeline: {issue_valid, is_first, is_last} shifted through a 1+SRAM_LAT stage register chain. is_first = issuing step 0. is_last = issuing step len-1. Both are qualified by issue_valid.
- tile_len=1: step 0 carries both first and last.
- tile_len=127: steps 0..126; the counter never emits 127 as a valid step.
- Counter width is 7 bits; no wrap is possible because len ≤ 127.

Test Plan:
- SRAM_LAT=1, tile_len=103, start at cycle T, no stall:
  - addr_serial_num 0 at T+1, ascending by 1, reaching 102 at T+103, 127 at T+104.
  - issue_valid T+1..T+103.
  - data_valid T+3..T+105; data_first at T+3 only; data_last at T+105 only.
  - done at T+106; busy T+1..T+106.
- Same run with stall=1 sampled at edges T+10..T+12:
  - addr_serial_num holds 9 for T+11..T+13, issue_valid=0 there, 10 at T+14.
  - Exactly 103 data_valid beats; done at T+109.
- tile_len=0, start at T: done=1 and busy=1 at T+1, IDLE at T+2; no issue_valid or data_valid; addr_serial_num stays 127.
- tile_len=1, SRAM_LAT=2: addr 0 valid at T+1; data_valid with first=last=1 at T+4; done at T+5.
- start pulsed again at T+50 during the 103-step run: ignored; a single done. A fresh start in the cycle after done is accepted.
- rst_n low at T+40 mid-run: outputs immediately 127/0, no done. After release, a start with tile_len=5 runs normally (addr 0..4, done at T'+8 with SRAM_LAT=1).
